// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional: MD_EARLY_OUT_EN ends multiplies once the multiplier is exhausted.
//
// Ports:
//   clk, reset (async, active-low)
//   start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), a, b
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured when not busy
//   busy, done, div_by_zero : handshake/status
//   hi, lo : architectural HI/LO
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dz;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   opb;

   logic               sa, sb, last;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     shl, diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo, rem, q_fix, r_fix;

   // Sign flags only matter for the signed ops (op[0]==0).
   assign sa    = ~op[0] & a[WIDTH-1];
   assign sb    = ~op[0] & b[WIDTH-1];
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

   // Divide: acc = {remainder, dividend/quotient}, restoring step.
   assign shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign diff = shl - {1'b0, opb};

   assign quo      = acc[WIDTH-1:0];
   assign rem      = acc[2*WIDTH-1:WIDTH];
   assign prod_fix = neg_q ? -acc : acc;
   assign q_fix    = dz ? '1 : (neg_q ? -quo : quo);
   // With b==0 the remainder is |a|, so this restores the raw a.
   assign r_fix    = neg_r ? -rem : rem;

`ifdef MD_EARLY_OUT_EN
   assign last = (cnt == CW'(WIDTH-1)) |
                 (~is_div & (opb[WIDTH-1:1] == '0));
`else
   assign last = (cnt == CW'(WIDTH-1));
`endif

   assign busy        = (state == CALC) | (state == FIX);
   assign done        = (state == DONE);
   assign div_by_zero = done & is_div & dz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         opb    <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               cnt    <= '0;
               is_div <= op[1];
               neg_q  <= sa ^ sb;
               neg_r  <= sa;
               dz     <= (b == '0);
               opb    <= mag_b;
               mcand  <= {{WIDTH{1'b0}}, mag_a};
               acc    <= op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  if (!diff[WIDTH])
                     acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  else
                     acc <= {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               end else begin
                  if (opb[0]) acc <= acc + mcand;
                  mcand <= mcand << 1;
                  opb   <= opb >> 1;
               end
            end
            default: ;
         endcase
      end
   end

   // Results land on the edge entering DONE; MTHI/MTLO only when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FIX) begin
         if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
         end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
         end
      end else if (!busy) begin
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random ops
// against a plain-arithmetic model of HI/LO, flags and latency.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 0;
   logic         reset = 0;
   logic         start = 0;
   logic         hi_we = 0;
   logic         lo_we = 0;
   logic [1:0]   op = 0;
   logic [W-1:0] a = 0;
   logic [W-1:0] b = 0;
   logic [W-1:0] wdata = 0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int tests = 0;
   int fails = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int calc_cycles(input logic [1:0] o,
                                      input logic [31:0] y);
      int c;
      c = W;
`ifdef MD_EARLY_OUT_EN
      if (!o[1]) begin
         logic [31:0] m;
         m = (!o[0] && y[31]) ? -y : y;
         c = 1;
         for (int i = 0; i < W; i++) if (m[i]) c = i + 1;
      end
`endif
      return c;
   endfunction

   task automatic model(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] eh,
                        output logic [31:0] el, output logic ed);
      logic signed [63:0] sx, sy, p, q, r;
      logic [63:0] u;
      ed = 0;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      case (o)
         2'b00: begin p = sx * sy; {eh, el} = p; end
         2'b01: begin u = {32'b0, x} * {32'b0, y}; {eh, el} = u; end
         default:
            if (y == 0) begin
               el = '1; eh = x; ed = 1;
            end else if (o == 2'b10) begin
               q = sx / sy; r = sx % sy;
               el = q[31:0]; eh = r[31:0];
            end else begin
               el = x / y; eh = x % y;
            end
      endcase
   endtask

   // poke>=0: at that cycle after start, try a new start plus MTHI
   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int poke);
      logic [31:0] eh, el;
      logic ed;
      int n, nb, lat;
      model(o, x, y, eh, el, ed);
      lat = calc_cycles(o, y) + 1;
      @(negedge clk);
      start = 1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 0; a = $urandom; b = $urandom;
      n = 0;
      nb = busy ? 1 : 0;
      while (!done && n < 200) begin
         if (n == poke) begin
            start = 1; hi_we = 1; wdata = 32'hAAAA;
            a = $urandom; b = $urandom; op = 2'($urandom);
         end
         @(posedge clk); #1;
         start = 0; hi_we = 0;
         n++;
         if (busy) nb++;
      end
      chk($sformatf("lat op%0d %h,%h", o, x, y), n, lat);
      chk("busy_cycles", nb, lat);
      chk($sformatf("hi op%0d %h,%h", o, x, y), hi, eh);
      chk($sformatf("lo op%0d %h,%h", o, x, y), lo, el);
      chk("dbz_at_done", div_by_zero, ed);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("dbz_one_cycle", div_by_zero, 0);
   endtask

   initial begin
      logic [31:0] eh, el, x, y;
      logic ed, saw;
      logic [1:0] o;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      @(negedge clk) reset = 1;

      run_op(2'b01, 32'd7, 32'd6, -1);
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, -1);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1);
      run_op(2'b11, 32'd100, 32'd7, -1);
      run_op(2'b11, 32'h1234, 32'd0, -1);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
      run_op(2'b10, 32'hFFFFFF00, 32'd0, -1);
      run_op(2'b00, 32'h80000000, 32'h80000000, -1);

      run_op(2'b01, 32'h12345678, 32'h9ABCDEF0, 5);
      model(2'b01, 32'h12345678, 32'h9ABCDEF0, eh, el, ed);
      @(negedge clk);
      lo_we = 1; wdata = 32'h55;
      @(posedge clk); #1;
      lo_we = 0;
      chk("mtlo_lo", lo, 32'h55);
      chk("mtlo_hi_kept", hi, eh);

      @(negedge clk);
      start = 1; op = 2'b01; a = 3; b = 3;
      @(posedge clk); #1;
      start = 0;
      repeat (10) @(posedge clk);
      #1 reset = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      saw = done;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw = 1;
      end
      chk("arst_no_done", saw, 0);
      @(negedge clk) reset = 1;
      run_op(2'b01, 32'd3, 32'd3, -1);

      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         if (i % 8 == 0) y = 0;
         else if (i % 3 == 0) y = y >> $urandom_range(1, 31);
         run_op(o, x, y, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
